// File: rtl/multdiv_unit_pkg.sv
// multdiv_unit_pkg: shared types and helpers for the HI/LO multiply/divide unit.
package multdiv_unit_pkg;

    typedef logic [31:0] word_t;
    typedef logic [63:0] dword_t;

    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} multdiv_op_t;
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} md_state_t;

    localparam int DIV_ITERS_DEFAULT = 32;

    function automatic dword_t mul_product(multdiv_op_t op, word_t a, word_t b);
        dword_t xa, xb;
        xa = {{32{op == MD_MULT && a[31]}}, a};
        xb = {{32{op == MD_MULT && b[31]}}, b};
        return xa * xb;
    endfunction

    // Returns {hi, lo} from magnitude quotient/remainder.
    function automatic dword_t div_fixup(word_t q, word_t r, logic a_neg, logic b_neg);
        return {a_neg ? -r : r, (a_neg ^ b_neg) ? -q : q};
    endfunction

endpackage

// File: rtl/multdiv_unit_divider_core.sv
// divider_core: restoring divider, one quotient bit per cycle; q/r show this cycle's step result.
module divider_core
    import multdiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [31:0] q,
    output logic [31:0] r
);
    word_t rem_q, quo_q, dvs_q, dvs_d, rem_in, quo_in;
    logic [32:0] sh;
    logic fits;

    // The load cycle already performs the first iteration.
    always_comb begin
        dvs_d  = load ? b_mag : dvs_q;
        rem_in = load ? '0 : rem_q;
        quo_in = load ? a_mag : quo_q;
        sh     = {rem_in, quo_in[31]};
        fits   = sh >= {1'b0, dvs_d};
        r      = fits ? sh[31:0] - dvs_d : sh[31:0];
        q      = {quo_in[30:0], fits};
    end

    always_ff @(posedge clk) begin
        dvs_q <= dvs_d;
        rem_q <= r;
        quo_q <= q;
    end

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit driving the mult_ok stall handshake.
// Define MULTDIV_DIV_EARLY_EN to finish divides by zero or with |a|<|b| in one cycle.
module multdiv_unit
    import multdiv_unit_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int DIV_ITERS   = DIV_ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        advance,
    input  logic        flush,
    output logic        ok,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CNT_MAX = (DIV_ITERS > MUL_LATENCY) ? DIV_ITERS : MUL_LATENCY;
    localparam int CW = $clog2(CNT_MAX + 1);

    md_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    multdiv_op_t   op_q, op_d, op_in;
    logic          a_neg_q, a_neg_d, b_neg_q, b_neg_d, a_neg_in, b_neg_in;
    word_t         hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, div_q, div_r, q_sel, r_sel;
    dword_t        mul_q [MUL_LATENCY];
    dword_t        mul_d [MUL_LATENCY];
    logic          is_div_in, early_hit, div_fast, launch, done_entry, cur_div, fix_a, fix_b;

    always_comb begin
        op_in     = multdiv_op_t'(op);
        is_div_in = op_in == MD_DIV || op_in == MD_DIVU;
        a_neg_in  = op_in == MD_DIV && a[31];
        b_neg_in  = op_in == MD_DIV && b[31];
        a_mag     = a_neg_in ? -a : a;
        b_mag     = b_neg_in ? -b : b;
    end

`ifdef MULTDIV_DIV_EARLY_EN
    assign early_hit = is_div_in && (b_mag == '0 || a_mag < b_mag);
`else
    assign early_hit = 1'b0;
`endif
    assign div_fast = early_hit || DIV_ITERS == 1;
    assign launch   = state_q == ST_IDLE && start && !flush;

    divider_core u_div (
        .clk  (clk),
        .load (state_q == ST_IDLE),
        .a_mag(a_mag),
        .b_mag(b_mag),
        .q    (div_q),
        .r    (div_r)
    );

    always_ff @(posedge clk) begin
        mul_q <= mul_d;
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULT;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // The launch cycle counts as the first busy cycle, so MUL/DIV finish at cnt==1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = is_div_in ? (div_fast ? ST_DONE : ST_DIV)
                                                    : (MUL_LATENCY == 1 ? ST_DONE : ST_MUL);
            ST_MUL, ST_DIV: if (cnt_q == CW'(1)) state_d = ST_DONE;
            ST_DONE: if (advance) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_comb ok = state_q == ST_DONE || (state_q == ST_IDLE && !start);

    always_comb begin
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        cnt_d    = (state_q == ST_MUL || state_q == ST_DIV) ? cnt_q - CW'(1) : cnt_q;
        mul_d[0] = mul_product(op_in, a, b);
        for (int i = 1; i < MUL_LATENCY; i++) mul_d[i] = mul_q[i - 1];
        if (launch) begin
            op_d    = op_in;
            a_neg_d = a_neg_in;
            b_neg_d = b_neg_in;
            cnt_d   = is_div_in ? CW'(DIV_ITERS - 1) : CW'(MUL_LATENCY - 1);
        end
        done_entry = state_d == ST_DONE && state_q != ST_DONE;
        cur_div    = state_q == ST_IDLE ? is_div_in : (op_q == MD_DIV || op_q == MD_DIVU);
        fix_a      = state_q == ST_IDLE ? a_neg_in : a_neg_q;
        fix_b      = state_q == ST_IDLE ? b_neg_in : b_neg_q;
        q_sel      = (early_hit && state_q == ST_IDLE) ? (b_mag == '0 ? '1 : '0) : div_q;
        r_sel      = (early_hit && state_q == ST_IDLE) ? a_mag : div_r;
        {hi_d, lo_d} = !done_entry ? {hi_q, lo_q}
                     : cur_div ? div_fixup(q_sel, r_sel, fix_a, fix_b)
                     : mul_d[MUL_LATENCY - 1];
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: scoreboard bench for multdiv_unit (honours MULTDIV_DIV_EARLY_EN for divide latency).
module tb_multdiv_unit;
    import multdiv_unit_pkg::*;

    typedef struct {
        word_t hi;
        word_t lo;
        int    lat;
    } exp_t;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0, advance = 1'b1, flush = 1'b0, ok;
    logic [1:0] op = 2'd0;
    word_t      a = '0, b = '0, hi, lo;
    exp_t       sb[$];
    int         n_cmp = 0, n_fail = 0;
    word_t      last_hi = '0, last_lo = '0;

    multdiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .advance(advance),
        .flush  (flush),
        .ok     (ok),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] o, input word_t x, input word_t y);
        exp_t e;
        logic [63:0] p;
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.lat = MUL_LAT;
        if (o == MD_MULT || o == MD_MULTU) begin
            p = (o == MD_MULT) ? 64'(sx * sy) : {32'b0, x} * {32'b0, y};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else begin
            e.lat = DIV_LAT;
            if (o == MD_DIVU) begin
                sx = longint'({32'b0, x});
                sy = longint'({32'b0, y});
            end
            if (y == 0) begin
                e.lo = (o == MD_DIV && x[31]) ? 32'h1 : 32'hFFFF_FFFF;
                e.hi = x;
            end else begin
                q = sx / sy;
                r = sx % sy;
                e.lo = q[31:0];
                e.hi = r[31:0];
            end
`ifdef MULTDIV_DIV_EARLY_EN
            if (y == 0 || (sx < 0 ? -sx : sx) < (sy < 0 ? -sy : sy)) e.lat = 1;
`endif
        end
        return e;
    endfunction

    // Raises start at a negedge and counts cycles with ok low until DONE (bounded).
    task automatic run_op(input logic [1:0] o, input word_t x, input word_t y,
                          output word_t oh, output word_t ol, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1; lat = 0;
        #1;
        while (!ok && lat < 100) begin
            lat++;
            @(negedge clk);
            #1;
        end
        oh = hi;
        ol = lo;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp += 3;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL reset_ok got %b want 1", ok); end
        if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
        if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
        start = 1'b1; flush = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd4;
        #1;
        n_cmp++;
        if (ok !== 1'b0) begin n_fail++; $display("FAIL ok_comb_start got %b want 0", ok); end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL flush_over_start got %b want 1", ok); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        op = MD_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
        repeat (9) @(negedge clk);
        #1;
        n_cmp++;
        if (ok !== 1'b0) begin n_fail++; $display("FAIL busy_iter10 got %b want 0", ok); end
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp += 3;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL div_flush_ok got %b want 1", ok); end
        if (hi !== last_hi) begin n_fail++; $display("FAIL div_flush_hi got %h want %h", hi, last_hi); end
        if (lo !== last_lo) begin n_fail++; $display("FAIL div_flush_lo got %h want %h", lo, last_lo); end
        repeat (40) @(negedge clk);
        #1;
        n_cmp += 2;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL div_flush_late_ok got %b want 1", ok); end
        if (lo !== last_lo) begin n_fail++; $display("FAIL div_flush_late_lo got %h want %h", lo, last_lo); end
        @(negedge clk);
        op = MD_MULT; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        n_cmp += 3;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL mul_flush_ok got %b want 1", ok); end
        if (hi !== last_hi) begin n_fail++; $display("FAIL mul_flush_hi got %h want %h", hi, last_hi); end
        if (lo !== last_lo) begin n_fail++; $display("FAIL mul_flush_lo got %h want %h", lo, last_lo); end
    endtask

    task automatic test_mult();
        logic [1:0] ops [5] = '{MD_MULT, MD_MULTU, MD_MULT, MD_MULT, MD_MULTU};
        word_t xs [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h1234_5678};
        word_t ys [5] = '{32'd3, 32'hFFFF_FFFF, 32'd6, 32'h8000_0000, 32'h9ABC_DEF0};
        word_t oh, ol;
        int lat;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(model(ops[i], xs[i], ys[i]));
            run_op(ops[i], xs[i], ys[i], oh, ol, lat);
            start = 1'b0;
            e = sb.pop_front();
            n_cmp += 3;
            if (oh !== e.hi) begin n_fail++; $display("FAIL mult%0d_hi got %h want %h", i, oh, e.hi); end
            if (ol !== e.lo) begin n_fail++; $display("FAIL mult%0d_lo got %h want %h", i, ol, e.lo); end
            if (lat !== e.lat) begin n_fail++; $display("FAIL mult%0d_lat got %0d want %0d", i, lat, e.lat); end
            last_hi = e.hi; last_lo = e.lo;
        end
        @(negedge clk);
        #1;
        n_cmp += 2;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL idle_after_mult_ok got %b want 1", ok); end
        if (lo !== last_lo) begin n_fail++; $display("FAIL idle_after_mult_lo got %h want %h", lo, last_lo); end
    endtask

    task automatic test_div();
        logic [1:0] ops [7] = '{MD_DIV, MD_DIVU, MD_DIV, MD_DIV, MD_DIV, MD_DIVU, MD_DIV};
        word_t xs [7] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 32'd3};
        word_t ys [7] = '{32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd10, 32'hFFFF_FFF7};
        word_t oh, ol;
        int lat;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            sb.push_back(model(ops[i], xs[i], ys[i]));
            run_op(ops[i], xs[i], ys[i], oh, ol, lat);
            start = 1'b0;
            e = sb.pop_front();
            n_cmp += 3;
            if (oh !== e.hi) begin n_fail++; $display("FAIL div%0d_hi got %h want %h", i, oh, e.hi); end
            if (ol !== e.lo) begin n_fail++; $display("FAIL div%0d_lo got %h want %h", i, ol, e.lo); end
            if (lat !== e.lat) begin n_fail++; $display("FAIL div%0d_lat got %0d want %0d", i, lat, e.lat); end
            last_hi = e.hi; last_lo = e.lo;
        end
    endtask

    task automatic test_done_hold();
        word_t oh, ol;
        int lat;
        exp_t e;
        sb.push_back(model(MD_MULT, 32'd12345, 32'hFFFF_FD52));
        run_op(MD_MULT, 32'd12345, 32'hFFFF_FD52, oh, ol, lat);
        e = sb.pop_front();
        n_cmp += 2;
        if (oh !== e.hi) begin n_fail++; $display("FAIL hold_hi got %h want %h", oh, e.hi); end
        if (ol !== e.lo) begin n_fail++; $display("FAIL hold_lo got %h want %h", ol, e.lo); end
        advance = 1'b0;
        a = 32'd77; b = 32'd88;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_cmp += 3;
            if (ok !== 1'b1) begin n_fail++; $display("FAIL hold%0d_ok got %b want 1", i, ok); end
            if (hi !== e.hi) begin n_fail++; $display("FAIL hold%0d_hi got %h want %h", i, hi, e.hi); end
            if (lo !== e.lo) begin n_fail++; $display("FAIL hold%0d_lo got %h want %h", i, lo, e.lo); end
        end
        advance = 1'b1; start = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL hold_release_ok got %b want 1", ok); end
        sb.push_back('{hi: 32'd0, lo: 32'd30, lat: MUL_LAT});
        run_op(MD_MULT, 32'd5, 32'd6, oh, ol, lat);
        start = 1'b0;
        e = sb.pop_front();
        n_cmp += 3;
        if (oh !== e.hi) begin n_fail++; $display("FAIL after_hold_hi got %h want %h", oh, e.hi); end
        if (ol !== e.lo) begin n_fail++; $display("FAIL after_hold_lo got %h want %h", ol, e.lo); end
        if (lat !== e.lat) begin n_fail++; $display("FAIL after_hold_lat got %0d want %0d", lat, e.lat); end
        last_hi = e.hi; last_lo = e.lo;
    endtask

    task automatic test_reset_mid();
        word_t oh, ol;
        int lat;
        exp_t e;
        @(negedge clk);
        op = MD_MULT; a = 32'd123; b = 32'd456; start = 1'b1;
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp += 3;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_ok got %b want 1", ok); end
        if (hi !== 32'h0) begin n_fail++; $display("FAIL rstmid_hi got %h want 0", hi); end
        if (lo !== 32'h0) begin n_fail++; $display("FAIL rstmid_lo got %h want 0", lo); end
        sb.push_back(model(MD_MULT, 32'd7, 32'd8));
        run_op(MD_MULT, 32'd7, 32'd8, oh, ol, lat);
        start = 1'b0;
        e = sb.pop_front();
        n_cmp += 2;
        if (ol !== e.lo) begin n_fail++; $display("FAIL rstmid_next_lo got %h want %h", ol, e.lo); end
        if (lat !== e.lat) begin n_fail++; $display("FAIL rstmid_next_lat got %0d want %0d", lat, e.lat); end
        last_hi = e.hi; last_lo = e.lo;
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops [8];
        word_t xs [8];
        word_t ys [8];
        word_t oh, ol;
        int lat;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            ops[i] = 2'($urandom_range(0, 3));
            xs[i] = $urandom;
            ys[i] = (i % 3 == 0) ? word_t'($urandom_range(0, 9)) : $urandom;
            sb.push_back(model(ops[i], xs[i], ys[i]));
        end
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], xs[i], ys[i], oh, ol, lat);
            start = 1'b0;
            e = sb.pop_front();
            n_cmp += 3;
            if (oh !== e.hi) begin n_fail++; $display("FAIL b2b%0d_hi op=%0d a=%h b=%h got %h want %h", i, ops[i], xs[i], ys[i], oh, e.hi); end
            if (ol !== e.lo) begin n_fail++; $display("FAIL b2b%0d_lo op=%0d a=%h b=%h got %h want %h", i, ops[i], xs[i], ys[i], ol, e.lo); end
            if (lat !== e.lat) begin n_fail++; $display("FAIL b2b%0d_lat got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_flush();
        test_mult();
        test_div();
        test_done_hold();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

endmodule
